spi_scan_sequencer: RTL and testbench

- Sequences the 8-bit SPI master to scan a multi-channel ADC.
- On a periodic tick it walks the enabled channels in ascending order. For each channel it runs one chip-select-framed multi-byte transaction, assembles the returned sample and presents it on a valid/ready stream.
- Sits between the SPI master (start/done/tx/rx) and the DAQ sample FIFO.

---
 rtl/spi_scan_pkg.sv | 32 +++
 rtl/scan_tick_gen.sv | 29 ++
 rtl/spi_scan_sequencer.sv | 154 +++++++++++++++
 tb/tb_spi_scan_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_scan_pkg.sv
// Shared types and helpers for the SPI ADC scan sequencer.
package spi_scan_pkg;

    localparam int   MAX_CHANNELS  = 32;
    localparam int   MAX_CH_W      = 5;
    localparam logic CMD_START_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CS_SETUP,
        ST_START_BYTE,
        ST_WAIT_BYTE,
        ST_CS_IDLE,
        ST_EMIT
    } seq_state_t;

    // Conversion command: start bit, 3-bit channel, four zero bits.
    function automatic logic [7:0] make_cmd(input logic [2:0] ch);
        return {CMD_START_BIT, ch, 4'b0000};
    endfunction

    function automatic logic [MAX_CH_W-1:0] lowest_set(input logic [MAX_CHANNELS-1:0] mask);
        logic [MAX_CH_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) idx = MAX_CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan period counter; tick_o marks the last cycle of each period.
module scan_tick_gen #(
    parameter int SCAN_PERIOD = 50000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                CNT_W    = $clog2(SCAN_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i || !en_i) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_o = en_i && (count == CNT_LAST);

endmodule

// File: rtl/spi_scan_sequencer.sv
// Walks the enabled ADC channels once per scan tick, framing one SPI
// transaction per channel and presenting each sample on a valid/ready stream.
module spi_scan_sequencer
    import spi_scan_pkg::*;
#(
    parameter  int NUM_CHANNELS    = 8,
    parameter  int BYTES_PER_FRAME = 3,
    parameter  int SCAN_PERIOD     = 50000,
    parameter  int CS_SETUP_CYCLES = 4,
    parameter  int CS_IDLE_CYCLES  = 4,
    localparam int CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int SAMPLE_W        = 8 * (BYTES_PER_FRAME - 1)
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [NUM_CHANNELS-1:0] channel_mask_i,
    output logic                    spi_start_o,
    input  logic                    spi_done_i,
    output logic [7:0]              spi_tx_o,
    input  logic [7:0]              spi_rx_i,
    output logic                    cs_n_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic [CH_W-1:0]         sample_channel_o,
    output logic [SAMPLE_W-1:0]     sample_data_o,
    output logic                    busy_o,
    output logic                    overrun_o
);

    localparam int BYTE_W = $clog2(BYTES_PER_FRAME);
    localparam int WAIT_MAX = (CS_SETUP_CYCLES > CS_IDLE_CYCLES) ? CS_SETUP_CYCLES : CS_IDLE_CYCLES;
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(BYTES_PER_FRAME - 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] IDLE_LAST  = WAIT_W'(CS_IDLE_CYCLES - 1);

    seq_state_t              state, state_next;
    logic                    tick;
    logic                    busy;
    logic                    last_byte;
    logic                    emit_fire;
    logic [NUM_CHANNELS-1:0] scan_mask;
    logic [CH_W-1:0]         cur_ch;
    logic [BYTE_W-1:0]       byte_idx;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [SAMPLE_W-1:0]     shift_reg;
    logic [7:0]              frame_tx;

    scan_tick_gen #(
        .SCAN_PERIOD(SCAN_PERIOD)
    ) u_tick (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .en_i   (enable_i),
        .tick_o (tick)
    );

    assign busy      = (state != ST_IDLE);
    assign busy_o    = busy;
    assign last_byte = (byte_idx == LAST_BYTE);
    assign emit_fire = (state == ST_EMIT) && (!sample_valid_o || sample_ready_i);
    assign frame_tx  = (byte_idx == '0) ? make_cmd(3'(cur_ch)) : 8'h00;

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        spi_start_o = 1'b0;
        spi_tx_o    = 8'h00;
        cs_n_o      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (tick && (channel_mask_i != '0)) state_next = ST_SELECT;
            end
            ST_SELECT: begin
                state_next = (scan_mask == '0) ? ST_IDLE : ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                cs_n_o = 1'b0;
                if (wait_cnt == SETUP_LAST) state_next = ST_START_BYTE;
            end
            ST_START_BYTE: begin
                cs_n_o      = 1'b0;
                spi_start_o = 1'b1;
                spi_tx_o    = frame_tx;
                state_next  = ST_WAIT_BYTE;
            end
            ST_WAIT_BYTE: begin
                // tx stays put until done so the master may sample it late
                cs_n_o   = 1'b0;
                spi_tx_o = frame_tx;
                if (spi_done_i) state_next = last_byte ? ST_CS_IDLE : ST_START_BYTE;
            end
            ST_CS_IDLE: begin
                if (wait_cnt == IDLE_LAST) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                // a disable mid-scan finishes the current sample, then drops the rest
                if (emit_fire) state_next = enable_i ? ST_SELECT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            scan_mask        <= '0;
            cur_ch           <= '0;
            byte_idx         <= '0;
            wait_cnt         <= '0;
            shift_reg        <= '0;
            sample_valid_o   <= 1'b0;
            sample_channel_o <= '0;
            sample_data_o    <= '0;
            overrun_o        <= 1'b0;
        end else begin
            if (tick && busy) overrun_o <= 1'b1;

            if ((state == ST_IDLE) && (state_next == ST_SELECT)) scan_mask <= channel_mask_i;

            if ((state == ST_SELECT) && (scan_mask != '0)) begin
                cur_ch    <= CH_W'(lowest_set(MAX_CHANNELS'(scan_mask)));
                scan_mask <= scan_mask & (scan_mask - NUM_CHANNELS'(1));
                byte_idx  <= '0;
            end

            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == ST_CS_SETUP) || (state == ST_CS_IDLE)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // byte 0 answers the command phase and carries no sample bits
            if ((state == ST_WAIT_BYTE) && spi_done_i) begin
                if (byte_idx != '0) shift_reg <= (shift_reg << 8) | SAMPLE_W'(spi_rx_i);
                if (!last_byte)     byte_idx  <= byte_idx + BYTE_W'(1);
            end

            if (emit_fire) begin
                sample_valid_o   <= 1'b1;
                sample_data_o    <= shift_reg;
                sample_channel_o <= cur_ch;
            end else if (sample_valid_o && sample_ready_i) begin
                sample_valid_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_scan_sequencer.sv
// Directed bench: SPI master/ADC model plus a scoreboard on the sample stream.
module tb_spi_scan_sequencer;

    localparam int CS_SETUP = 4;
    localparam int CS_IDLE  = 4;
    localparam int LAT      = 3;

    logic        clock_i;
    logic        reset_i;
    logic        enable_i;
    logic [7:0]  channel_mask_i;
    logic        spi_start_o;
    logic        spi_done_i;
    logic [7:0]  spi_tx_o;
    logic [7:0]  spi_rx_i;
    logic        cs_n_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [2:0]  sample_channel_o;
    logic [15:0] sample_data_o;
    logic        busy_o;
    logic        overrun_o;

    spi_scan_sequencer #(
        .NUM_CHANNELS   (8),
        .BYTES_PER_FRAME(3),
        .SCAN_PERIOD    (100),
        .CS_SETUP_CYCLES(CS_SETUP),
        .CS_IDLE_CYCLES (CS_IDLE)
    ) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .channel_mask_i  (channel_mask_i),
        .spi_start_o     (spi_start_o),
        .spi_done_i      (spi_done_i),
        .spi_tx_o        (spi_tx_o),
        .spi_rx_i        (spi_rx_i),
        .cs_n_o          (cs_n_o),
        .sample_valid_o  (sample_valid_o),
        .sample_ready_i  (sample_ready_i),
        .sample_channel_o(sample_channel_o),
        .sample_data_o   (sample_data_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_log[$];
    int checks   = 0;
    int failures = 0;
    int cycle = 0;
    int starts_total = 0;
    int samples_seen = 0;

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] adc_value(input logic [2:0] ch);
        return 16'(ch) * 16'h0111;
    endfunction

    // SPI master + ADC model: done LAT cycles after each start, replies from the command channel.
    initial begin
        int         last_done_cycle = 0;
        int         cs_low_run = 0;
        int         cs_high_run = 0;
        int         frame_byte = 0;
        int         wait_left = 0;
        bit         pending = 0;
        logic       prev_start = 1'b0;
        logic [2:0] frame_ch = '0;
        logic [7:0] reply = '0;
        logic [15:0] val;
        spi_done_i = 1'b0;
        spi_rx_i   = 8'h00;
        forever begin
            @(negedge clock_i);
            #1;
            cycle++;
            spi_done_i = 1'b0;
            if (reset_i) begin
                pending     = 0;
                frame_byte  = 0;
                cs_low_run  = 0;
                cs_high_run = 0;
                prev_start  = 1'b0;
            end else begin
                if (pending) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        spi_done_i      = 1'b1;
                        spi_rx_i        = reply;
                        pending         = 0;
                        last_done_cycle = cycle;
                    end
                end
                if (spi_start_o) begin
                    starts_total++;
                    check("start_single_cycle", prev_start, 1'b0);
                    check("start_cs_low", cs_n_o, 1'b0);
                    tx_log.push_back(spi_tx_o);
                    if (frame_byte == 0) begin
                        check("cs_setup_cycles", cs_low_run, CS_SETUP);
                        check("cmd_format", {spi_tx_o[7], spi_tx_o[3:0]}, 5'b1_0000);
                        frame_ch = spi_tx_o[6:4];
                        reply    = 8'hFF;
                    end else begin
                        check("start_after_done", cycle - last_done_cycle, 1);
                        check("tx_data_byte", spi_tx_o, 8'h00);
                        val   = adc_value(frame_ch);
                        reply = (frame_byte == 1) ? val[15:8] : val[7:0];
                    end
                    frame_byte++;
                    pending   = 1;
                    wait_left = LAT;
                end
                if (cs_n_o) begin
                    frame_byte = 0;
                    cs_low_run = 0;
                    cs_high_run++;
                end else begin
                    if (cs_low_run == 0) check("cs_idle_cycles", cs_high_run >= CS_IDLE, 1'b1);
                    cs_low_run++;
                    cs_high_run = 0;
                end
                prev_start = spi_start_o;
            end
        end
    end

    // Scoreboard monitor: every accepted sample pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_i);
            #1;
            if (!reset_i && sample_valid_o && sample_ready_i) begin
                samples_seen++;
                check("sample_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sample_channel", sample_channel_o, e.ch);
                    check("sample_data", sample_data_o, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [2:0] ch, input logic [15:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_i        = 1'b1;
        enable_i       = 1'b0;
        channel_mask_i = 8'h00;
        sample_ready_i = 1'b1;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    task automatic wait_samples(input int target, input int budget, input string name);
        int n = 0;
        while (samples_seen < target && n < budget) begin
            @(negedge clock_i);
            n++;
        end
        check(name, samples_seen >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clock_i);
            n++;
        end
        check(name, busy_o, 1'b0);
    endtask

    initial begin
        int          n;
        int          base_starts;
        int          base_samples;
        logic        busy_seen;
        logic [7:0]  exp_tx [6];
        exp_tx = '{8'h80, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00};

        // Reset state
        @(negedge clock_i);
        do_reset();
        check("rst_cs_n", cs_n_o, 1'b1);
        check("rst_start", spi_start_o, 1'b0);
        check("rst_tx", spi_tx_o, 8'h00);
        check("rst_valid", sample_valid_o, 1'b0);
        check("rst_channel", sample_channel_o, 3'd0);
        check("rst_data", sample_data_o, 16'h0000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);

        // Mask 0b101: ch0 then ch2, first tick 100 cycles after enable
        tx_log.delete();
        base_starts    = starts_total;
        base_samples   = samples_seen;
        push_exp(3'd0, 16'h0000);
        push_exp(3'd2, 16'h0222);
        channel_mask_i = 8'b0000_0101;
        enable_i       = 1'b1;
        n = 0;
        while (!busy_o && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        check("first_tick_latency", n, 100);
        wait_samples(base_samples + 2, 300, "t1_samples_timeout");
        wait_idle(50, "t1_idle");
        enable_i = 1'b0;
        check("t1_start_count", starts_total - base_starts, 6);
        check("t1_tx_count", tx_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < tx_log.size()) check("t1_tx_byte", tx_log[i], exp_tx[i]);
        end
        check("t1_overrun", overrun_o, 1'b0);

        // Consumer stalled across ticks: sample holds, EMIT stalls, overrun sticks
        do_reset();
        sample_ready_i = 1'b0;
        channel_mask_i = 8'h01;
        enable_i       = 1'b1;
        base_samples   = samples_seen;
        repeat (320) @(negedge clock_i);
        check("t2_valid_held", sample_valid_o, 1'b1);
        check("t2_channel_held", sample_channel_o, 3'd0);
        check("t2_data_held", sample_data_o, 16'h0000);
        check("t2_stalled_busy", busy_o, 1'b1);
        check("t2_stalled_cs", cs_n_o, 1'b1);
        check("t2_overrun", overrun_o, 1'b1);
        check("t2_no_accept", samples_seen - base_samples, 0);
        push_exp(3'd0, 16'h0000);
        push_exp(3'd0, 16'h0000);
        sample_ready_i = 1'b1;
        enable_i       = 1'b0;
        wait_samples(base_samples + 2, 50, "t2_samples_timeout");
        repeat (10) @(negedge clock_i);
        check("t2_overrun_sticky", overrun_o, 1'b1);
        check("t2_idle", busy_o, 1'b0);
        check("t2_valid_drained", sample_valid_o, 1'b0);

        // Empty mask: ticks are ignored
        do_reset();
        base_starts    = starts_total;
        channel_mask_i = 8'h00;
        enable_i       = 1'b1;
        busy_seen      = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock_i);
            busy_seen = busy_seen | busy_o;
        end
        enable_i = 1'b0;
        check("t3_no_starts", starts_total - base_starts, 0);
        check("t3_never_busy", busy_seen, 1'b0);
        check("t3_overrun", overrun_o, 1'b0);

        // Disable during byte 1 of ch0: frame finishes, ch1 never starts
        do_reset();
        base_starts    = starts_total;
        base_samples   = samples_seen;
        channel_mask_i = 8'h03;
        enable_i       = 1'b1;
        n = 0;
        while (starts_total - base_starts < 2 && n < 300) begin
            @(negedge clock_i);
            n++;
        end
        check("t4_reach_byte1", starts_total - base_starts, 2);
        enable_i = 1'b0;
        push_exp(3'd0, 16'h0000);
        wait_samples(base_samples + 1, 100, "t4_samples_timeout");
        repeat (40) @(negedge clock_i);
        check("t4_start_count", starts_total - base_starts, 3);
        check("t4_idle", busy_o, 1'b0);
        check("t4_cs_high", cs_n_o, 1'b1);
        check("t4_sample_count", samples_seen - base_samples, 1);

        // Reset during WAIT_BYTE aborts cleanly; the next scan is correct
        do_reset();
        base_starts    = starts_total;
        base_samples   = samples_seen;
        channel_mask_i = 8'h04;
        enable_i       = 1'b1;
        n = 0;
        while (starts_total == base_starts && n < 300) begin
            @(negedge clock_i);
            n++;
        end
        check("t5_first_start", starts_total - base_starts, 1);
        reset_i = 1'b1;
        @(negedge clock_i);
        check("t5_rst_cs_n", cs_n_o, 1'b1);
        check("t5_rst_valid", sample_valid_o, 1'b0);
        check("t5_rst_busy", busy_o, 1'b0);
        check("t5_rst_overrun", overrun_o, 1'b0);
        check("t5_rst_start", spi_start_o, 1'b0);
        reset_i = 1'b0;
        push_exp(3'd2, 16'h0222);
        wait_samples(base_samples + 1, 300, "t5_samples_timeout");
        wait_idle(50, "t5_idle");
        enable_i = 1'b0;
        check("t5_sample_count", samples_seen - base_samples, 1);

        // All channels, ready tied high
        do_reset();
        base_starts    = starts_total;
        base_samples   = samples_seen;
        for (int c = 0; c < 8; c++) push_exp(3'(c), adc_value(3'(c)));
        channel_mask_i = 8'hFF;
        enable_i       = 1'b1;
        wait_samples(base_samples + 8, 400, "t6_samples_timeout");
        enable_i = 1'b0;
        wait_idle(50, "t6_idle");
        repeat (20) @(negedge clock_i);
        check("t6_start_count", starts_total - base_starts, 24);
        check("t6_sample_count", samples_seen - base_samples, 8);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
